// File: rtl/conv5x5_window_scheduler.sv
// Job sequencer for the 5x5 Float8 convolution: loads weights once, then fetches, evaluates and stores every window.
// Optional macro CONV_RELU_EN: negative results (sign bit set) are stored as zero.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | reading the 25 weights into conv_b
// FETCH  | reading the 25 window pixels into conv_a
// CALC   | operands stable, latch conv_y and overflow
// WRITE  | result RAM write, advance window
// DONE   | one-cycle done pulse

module conv5x5_window_scheduler #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PX_AW  = 10,
    parameter int RES_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              w_rd_o,
    output logic [4:0]        w_addr_o,
    input  logic [7:0]        w_data_i,
    output logic              px_rd_o,
    output logic [PX_AW-1:0]  px_addr_o,
    input  logic [7:0]        px_data_i,
    output logic [199:0]      conv_a_o,
    output logic [199:0]      conv_b_o,
    input  logic [7:0]        conv_y_i,
    input  logic              conv_ovf_i,
    output logic              res_we_o,
    output logic [RES_AW-1:0] res_addr_o,
    output logic [7:0]        res_data_o,
    output logic              ovf_flag_o
);

    localparam int OXW = $clog2(IMG_W);
    localparam int OYW = $clog2(IMG_H);
    localparam logic [OXW-1:0]   OX_LAST  = OXW'(IMG_W - 5);
    localparam logic [OYW-1:0]   OY_LAST  = OYW'(IMG_H - 5);
    localparam logic [PX_AW-1:0] ROW_STEP = PX_AW'(IMG_W - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_FETCH,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [4:0]          k_q;
    logic [2:0]          kc_q;
    logic [OXW-1:0]      ox_q;
    logic [OYW-1:0]      oy_q;
    logic [RES_AW-1:0]   win_q;
    logic [PX_AW-1:0]    base_q;
    logic                busy_q;
    logic                done_q;
    logic                w_rd_q;
    logic [4:0]          w_addr_q;
    logic                px_rd_q;
    logic [PX_AW-1:0]    px_addr_q;
    logic [199:0]        conv_a_q;
    logic [199:0]        conv_b_q;
    logic                res_we_q;
    logic [RES_AW-1:0]   res_addr_q;
    logic [7:0]          res_data_q;
    logic                ovf_q;

    logic [7:0]          res_data_d;
    logic [PX_AW-1:0]    px_addr_d;
    logic [PX_AW-1:0]    base_d;
    logic [4:0]          k_m1;
    logic                last_win;

    always_comb begin
        res_data_d = conv_y_i;
`ifdef CONV_RELU_EN
        if (conv_y_i[7]) begin
            res_data_d = 8'h00;
        end
`endif
        // Within a window: step one column, or wrap to the first column of the next kernel row.
        px_addr_d = (kc_q == 3'd4) ? px_addr_q + ROW_STEP : px_addr_q + PX_AW'(1);
        // Window origin: next column, or first column of the next row (IMG_W-5 + 5).
        base_d    = (ox_q == OX_LAST) ? base_q + PX_AW'(5) : base_q + PX_AW'(1);
        k_m1      = k_q - 5'd1;
        last_win  = (ox_q == OX_LAST) && (oy_q == OY_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            kc_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            win_q      <= '0;
            base_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_rd_q     <= 1'b0;
            w_addr_q   <= '0;
            px_rd_q    <= 1'b0;
            px_addr_q  <= '0;
            conv_a_q   <= '0;
            conv_b_q   <= '0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q  <= S_LOAD_W;
                        busy_q   <= 1'b1;
                        ovf_q    <= 1'b0;
                        ox_q     <= '0;
                        oy_q     <= '0;
                        win_q    <= '0;
                        base_q   <= '0;
                        k_q      <= '0;
                        w_rd_q   <= 1'b1;
                        w_addr_q <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (k_q != 5'd0) begin
                        conv_b_q[{k_m1, 3'b000} +: 8] <= w_data_i;
                    end
                    if (k_q == 5'd25) begin
                        state_q   <= S_FETCH;
                        k_q       <= '0;
                        kc_q      <= '0;
                        px_rd_q   <= 1'b1;
                        px_addr_q <= base_q;
                    end else begin
                        k_q      <= k_q + 5'd1;
                        w_rd_q   <= (k_q < 5'd24);
                        w_addr_q <= k_q + 5'd1;
                    end
                end
                S_FETCH: begin
                    if (k_q != 5'd0) begin
                        conv_a_q[{k_m1, 3'b000} +: 8] <= px_data_i;
                    end
                    if (k_q == 5'd25) begin
                        state_q <= S_CALC;
                    end else begin
                        k_q       <= k_q + 5'd1;
                        kc_q      <= (kc_q == 3'd4) ? 3'd0 : kc_q + 3'd1;
                        px_rd_q   <= (k_q < 5'd24);
                        px_addr_q <= px_addr_d;
                    end
                end
                S_CALC: begin
                    res_data_q <= res_data_d;
                    res_addr_q <= win_q;
                    ovf_q      <= ovf_q | conv_ovf_i;
                    res_we_q   <= 1'b1;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    res_we_q <= 1'b0;
                    win_q    <= win_q + RES_AW'(1);
                    base_q   <= base_d;
                    if (ox_q == OX_LAST) begin
                        ox_q <= '0;
                        oy_q <= oy_q + OYW'(1);
                    end else begin
                        ox_q <= ox_q + OXW'(1);
                    end
                    if (last_win) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_FETCH;
                        k_q       <= '0;
                        kc_q      <= '0;
                        px_rd_q   <= 1'b1;
                        px_addr_q <= base_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign w_rd_o     = w_rd_q;
    assign w_addr_o   = w_addr_q;
    assign px_rd_o    = px_rd_q;
    assign px_addr_o  = px_addr_q;
    assign conv_a_o   = conv_a_q;
    assign conv_b_o   = conv_b_q;
    assign res_we_o   = res_we_q;
    assign res_addr_o = res_addr_q;
    assign res_data_o = res_data_q;
    assign ovf_flag_o = ovf_q;

endmodule
